wb_core_master: RTL and testbench
=================================

Name: wb_core_master

Overview:
- Wishbone pipelined-mode master (initiator) that drives single-word reads and writes onto the shared Wishbone bus on behalf of a core.
- Converts a simple core-side memory request (enable / writeEnable / busy) into one Wishbone cycle per request: stb, stall, ack and error handling, plus a bus timeout.
- Sits between the core's memory port and the bus fabric. Its transactions terminate at responders such as the SRAM/management Wishbone slave.

Parameters:
- ADDR_WIDTH, 28, width of wb_adr_o and coreAddress.
- TIMEOUT_CYCLES, 255, cycles allowed from stb issue to ack/error before the cycle is aborted. Range 1..255; the counter is 8 bits.

Ports:
- wb_clk_i  in  1  bus clock; all logic is on its rising edge.
- wb_rst_i  in  1  asynchronous, active-low reset.
- coreAddress  in  ADDR_WIDTH  request word/byte address.
- coreByteSelect  in  4  byte lanes.
- coreEnable  in  1  request valid; held by the core until coreBusy is low.
- coreWriteEnable  in  1  1 = write, 0 = read.
- coreDataWrite  in  32  write data.
- coreDataRead  out  32  read data, valid while coreBusy is low after a request.
- coreBusy  out  1  request in progress.
- coreError  out  1  last request ended with wb_error_i or timeout.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  4  byte select.
- wb_adr_o  out  ADDR_WIDTH  address.
- wb_data_o  out  32  write data.
- wb_data_i  in  32  read data.
- wb_ack_i  in  1  acknowledge.
- wb_stall_i  in  1  slave stall.
- wb_error_i  in  1  slave error.

Behaviour:
- Reset (wb_rst_i low, asynchronous): state IDLE.
  - wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_sel_o, wb_adr_o, wb_data_o = 0.
  - coreDataRead = 32'hFFFFFFFF; coreError = 0; timeout counter = 0.
  - Reset asserted mid-cycle drops cyc/stb immediately. No ack is reported to the core.
- States: IDLE, ISSUE, WAIT_ACK, FINISH.
- IDLE:
  - coreBusy = coreEnable (combinational), so it rises in the same cycle as the request.
  - On coreEnable: latch address, sel, we and write data into registers; clear the counter and coreError; go to ISSUE.
- ISSUE:
  - wb_cyc_o = wb_stb_o = 1; registered request values drive the bus.
  - Counter increments every cycle.
  - If wb_stall_i = 0 the strobe is accepted. If wb_ack_i or wb_error_i is also present that cycle, go directly to FINISH; otherwise go to WAIT_ACK.
  - If wb_stall_i = 1, stay in ISSUE. ack/error are ignored while stalled.
- WAIT_ACK:
  - wb_cyc_o = 1, wb_stb_o = 0; counter increments.
  - On wb_ack_i: go to FINISH. For a read, coreDataRead <= wb_data_i.
  - On wb_error_i (takes priority over a simultaneous ack): go to FINISH with coreError <= 1 and coreDataRead <= 32'hFFFFFFFF.
- Timeout: when the counter reaches TIMEOUT_CYCLES in ISSUE or WAIT_ACK with no ack/error, go to FINISH with coreError = 1 and coreDataRead = 32'hFFFFFFFF.
- FINISH:
  - wb_cyc_o = wb_stb_o = 0; coreBusy = 0 for exactly one cycle; then unconditionally go to IDLE.
  - A request still held in FINISH is treated as a new request and is accepted in the following IDLE cycle.
- A write leaves coreDataRead unchanged.
- coreError and coreDataRead hold until the next request is accepted.
- Minimum latency is 3 cycles from IDLE with coreEnable to coreBusy low: IDLE, ISSUE (with ack), FINISH.
- A late ack arriving while cyc = 0 is ignored.
- coreEnable dropping mid-transaction does not abort the bus cycle.

Test Plan:
- Read, no stall: ack in the cycle after stb, wb_data_i = 32'hDEADBEEF, address 0x0000100 -> one stb cycle; busy low in cycle 4; coreDataRead = DEADBEEF; coreError = 0.
- Write with 3 stall cycles: sel = 4'b0011, data 0x12345678 -> stb held 4 cycles with stable adr/sel/data and we = 1; cyc drops in FINISH.
- Slave error: wb_error_i = 1 on a read -> coreError = 1, coreDataRead = FFFFFFFF, busy low one cycle.
- Timeout: TIMEOUT_CYCLES = 8, slave never acks -> FINISH after 8 cycles in ISSUE/WAIT_ACK; coreError = 1; cyc = 0.
- Back-to-back: coreEnable held across two reads -> second cyc starts two cycles after the first FINISH; no ack is double-counted.
- Reset low asserted during WAIT_ACK -> cyc/stb = 0 immediately; coreDataRead = FFFFFFFF; state IDLE after release.

Source files
------------

// File: rtl/wb_core_master.sv
// Single-word Wishbone pipelined master: one bus cycle per core request, 3-cycle minimum request-to-done latency.
// Holds strobe while the slave stalls; an error or the cycle timeout ends the request with coreError set.
module wb_core_master #(
    parameter int ADDR_WIDTH     = 28,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [ADDR_WIDTH-1:0] coreAddress,
    input  logic [3:0]            coreByteSelect,
    input  logic                  coreEnable,
    input  logic                  coreWriteEnable,
    input  logic [31:0]           coreDataWrite,
    output logic [31:0]           coreDataRead,
    output logic                  coreBusy,
    output logic                  coreError,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [3:0]            wb_sel_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [31:0]           wb_data_o,
    input  logic [31:0]           wb_data_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_stall_i,
    input  logic                  wb_error_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, FINISH} state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [3:0]            sel_q, sel_d;
    logic                  we_q, we_d;
    logic [31:0]           wdat_q, wdat_d;
    logic [31:0]           rdat_q, rdat_d;
    logic                  err_q, err_d;
    logic [7:0]            cnt_inc;
    logic                  timeout;

    assign cnt_inc = cnt_q + 8'd1;
    // Fires on the last permitted cycle so FINISH follows exactly TIMEOUT_CYCLES bus cycles.
    assign timeout = (cnt_inc == TIMEOUT_LIM);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        sel_d    = sel_q;
        we_d     = we_q;
        wdat_d   = wdat_q;
        rdat_d   = rdat_q;
        err_d    = err_q;
        coreBusy = 1'b0;
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        case (state_q)
            IDLE: begin
                coreBusy = coreEnable;
                if (coreEnable) begin
                    adr_d   = coreAddress;
                    sel_d   = coreByteSelect;
                    we_d    = coreWriteEnable;
                    wdat_d  = coreDataWrite;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                coreBusy = 1'b1;
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                cnt_d    = cnt_inc;
                if (!wb_stall_i && wb_error_i) begin
                    err_d   = 1'b1;
                    rdat_d  = 32'hFFFF_FFFF;
                    state_d = FINISH;
                end else if (!wb_stall_i && wb_ack_i) begin
                    if (!we_q) rdat_d = wb_data_i;
                    state_d = FINISH;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    rdat_d  = 32'hFFFF_FFFF;
                    state_d = FINISH;
                end else if (!wb_stall_i) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                coreBusy = 1'b1;
                wb_cyc_o = 1'b1;
                cnt_d    = cnt_inc;
                if (wb_error_i || (timeout && !wb_ack_i)) begin
                    err_d   = 1'b1;
                    rdat_d  = 32'hFFFF_FFFF;
                    state_d = FINISH;
                end else if (wb_ack_i) begin
                    if (!we_q) rdat_d = wb_data_i;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            adr_q   <= '0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            wdat_q  <= 32'd0;
            rdat_q  <= 32'hFFFF_FFFF;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end
    end

    assign wb_we_o      = we_q;
    assign wb_sel_o     = sel_q;
    assign wb_adr_o     = adr_q;
    assign wb_data_o    = wdat_q;
    assign coreDataRead = rdat_q;
    assign coreError    = err_q;

endmodule

// File: tb/tb_wb_core_master.sv
// Directed bench for wb_core_master: table of single transactions plus back-to-back and mid-cycle reset sequences.
module tb_wb_core_master;

    localparam int AW = 28;
    localparam logic [1:0] R_ACK = 2'd0, R_ERR = 2'd1, R_BOTH = 2'd2, R_NONE = 2'd3;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i;
    logic [AW-1:0] coreAddress;
    logic [3:0]    coreByteSelect;
    logic          coreEnable;
    logic          coreWriteEnable;
    logic [31:0]   coreDataWrite;
    logic [31:0]   coreDataRead;
    logic          coreBusy;
    logic          coreError;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [3:0]    wb_sel_o;
    logic [AW-1:0] wb_adr_o;
    logic [31:0]   wb_data_o;
    logic [31:0]   wb_data_i;
    logic          wb_ack_i;
    logic          wb_stall_i;
    logic          wb_error_i;

    wb_core_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .coreAddress     (coreAddress),
        .coreByteSelect  (coreByteSelect),
        .coreEnable      (coreEnable),
        .coreWriteEnable (coreWriteEnable),
        .coreDataWrite   (coreDataWrite),
        .coreDataRead    (coreDataRead),
        .coreBusy        (coreBusy),
        .coreError       (coreError),
        .wb_cyc_o        (wb_cyc_o),
        .wb_stb_o        (wb_stb_o),
        .wb_we_o         (wb_we_o),
        .wb_sel_o        (wb_sel_o),
        .wb_adr_o        (wb_adr_o),
        .wb_data_o       (wb_data_o),
        .wb_data_i       (wb_data_i),
        .wb_ack_i        (wb_ack_i),
        .wb_stall_i      (wb_stall_i),
        .wb_error_i      (wb_error_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [3:0]    sel;
        logic [31:0]   wdat;
        int            stall_n;
        int            ack_dly;
        logic [1:0]    resp;
        logic [31:0]   rdat;
        int            exp_fin;
        int            exp_stb;
        logic          exp_err;
        logic [31:0]   exp_rd;
    } vec_t;

    vec_t vt[10];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        coreEnable      = 1'b0;
        coreWriteEnable = 1'b0;
        coreAddress     = '0;
        coreByteSelect  = 4'd0;
        coreDataWrite   = 32'd0;
        wb_data_i       = 32'd0;
        wb_ack_i        = 1'b0;
        wb_stall_i      = 1'b0;
        wb_error_i      = 1'b0;
    endtask

    // Slave responses follow a fixed cycle schedule: cycle 1 is the request cycle, stb is accepted at cycle 2+stall_n.
    task automatic run_vec(input int idx, input vec_t v);
        int   fin;
        int   stbs;
        int   acc;
        int   rc;
        logic cyc_at_fin;
        logic err_at_fin;
        logic [31:0] rd_at_fin;
        fin = 0; stbs = 0; cyc_at_fin = 1'b1; err_at_fin = 1'bx; rd_at_fin = 32'hx;
        acc = 2 + v.stall_n;
        rc  = acc + v.ack_dly;
        for (int c = 1; c <= 40 && fin == 0; c++) begin
            @(negedge wb_clk_i);
            coreEnable      = 1'b1;
            coreWriteEnable = v.we;
            coreAddress     = v.adr;
            coreByteSelect  = v.sel;
            coreDataWrite   = v.wdat;
            wb_stall_i      = (c >= 2) && (c < acc);
            wb_ack_i        = (c == rc) && (v.resp == R_ACK || v.resp == R_BOTH);
            wb_error_i      = (c == rc) && (v.resp == R_ERR || v.resp == R_BOTH);
            wb_data_i       = (c == rc) ? v.rdat : 32'h0;
            #1;
            if (wb_stb_o) begin
                stbs++;
                chk($sformatf("v%0d stb adr", idx), 32'(wb_adr_o), 32'(v.adr));
                chk($sformatf("v%0d stb we/sel", idx), {27'd0, wb_we_o, wb_sel_o}, {27'd0, v.we, v.sel});
                chk($sformatf("v%0d stb wdata", idx), wb_data_o, v.wdat);
            end
            if (!coreBusy) begin
                fin        = c;
                cyc_at_fin = wb_cyc_o | wb_stb_o;
                err_at_fin = coreError;
                rd_at_fin  = coreDataRead;
            end
        end
        chk($sformatf("v%0d finish cycle", idx), 32'(fin), 32'(v.exp_fin));
        chk($sformatf("v%0d stb cycles", idx), 32'(stbs), 32'(v.exp_stb));
        chk($sformatf("v%0d cyc in finish", idx), {31'd0, cyc_at_fin}, 32'd0);
        chk($sformatf("v%0d error", idx), {31'd0, err_at_fin}, {31'd0, v.exp_err});
        chk($sformatf("v%0d rdata", idx), rd_at_fin, v.exp_rd);
        // A stray ack while idle must not reach the core.
        @(negedge wb_clk_i);
        idle_inputs();
        wb_ack_i  = 1'b1;
        wb_data_i = 32'hBAD0_BAD0;
        #1;
        chk($sformatf("v%0d idle busy/cyc", idx), {30'd0, coreBusy, wb_cyc_o}, 32'd0);
        @(negedge wb_clk_i);
        idle_inputs();
        #1;
        chk($sformatf("v%0d rdata hold", idx), coreDataRead, v.exp_rd);
        chk($sformatf("v%0d error hold", idx), {31'd0, coreError}, {31'd0, v.exp_err});
    endtask

    logic [6:0] cyc_pat, stb_pat, busy_pat;

    initial begin
        //        we    adr           sel     wdat          stall dly resp    rdat          fin stb err   exp_rd
        vt[0] = '{1'b0, 28'h0000100, 4'hF,   32'h0,        0,  1,  R_ACK,  32'hDEADBEEF, 4,  1,  1'b0, 32'hDEADBEEF};
        vt[1] = '{1'b1, 28'h0000200, 4'b0011, 32'h12345678, 3,  1,  R_ACK,  32'h0,        7,  4,  1'b0, 32'hDEADBEEF};
        vt[2] = '{1'b0, 28'h0000304, 4'hF,   32'h0,        0,  0,  R_ACK,  32'hCAFEF00D, 3,  1,  1'b0, 32'hCAFEF00D};
        vt[3] = '{1'b0, 28'h0000308, 4'hF,   32'h0,        0,  1,  R_ERR,  32'h55555555, 4,  1,  1'b1, 32'hFFFFFFFF};
        vt[4] = '{1'b0, 28'h000030C, 4'hF,   32'h0,        1,  2,  R_ACK,  32'h0BADF00D, 6,  2,  1'b0, 32'h0BADF00D};
        vt[5] = '{1'b0, 28'h0000310, 4'hF,   32'h0,        0,  0,  R_BOTH, 32'h11111111, 3,  1,  1'b1, 32'hFFFFFFFF};
        vt[6] = '{1'b1, 28'hFFFFFFC, 4'b1100, 32'h89ABCDEF, 0,  2,  R_ACK,  32'h0,        5,  1,  1'b0, 32'hFFFFFFFF};
        vt[7] = '{1'b0, 28'h0000400, 4'hF,   32'h0,        0,  1,  R_NONE, 32'h0,        10, 1,  1'b1, 32'hFFFFFFFF};
        vt[8] = '{1'b0, 28'h0000404, 4'hF,   32'h0,        20, 1,  R_NONE, 32'h0,        10, 8,  1'b1, 32'hFFFFFFFF};
        vt[9] = '{1'b0, 28'h0000408, 4'hF,   32'h0,        0,  1,  R_ACK,  32'hA5A55A5A, 4,  1,  1'b0, 32'hA5A55A5A};

        idle_inputs();
        wb_rst_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        #1;
        chk("reset cyc/stb/we", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        chk("reset sel/adr", {wb_sel_o, wb_adr_o}, 32'd0);
        chk("reset wdata", wb_data_o, 32'd0);
        chk("reset rdata", coreDataRead, 32'hFFFFFFFF);
        chk("reset err/busy", {30'd0, coreError, coreBusy}, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);

        for (int i = 0; i < 10; i++) run_vec(i, vt[i]);

        // Back-to-back reads with coreEnable held: second accept in the IDLE right after FINISH.
        cyc_pat = '0; stb_pat = '0; busy_pat = '0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge wb_clk_i);
            idle_inputs();
            coreEnable     = (c <= 6);
            coreAddress    = 28'h0000500;
            coreByteSelect = 4'hF;
            wb_ack_i       = (c == 2) || (c == 5);
            wb_data_i      = (c == 2) ? 32'h00000001 : (c == 5) ? 32'h00000002 : 32'h0;
            #1;
            cyc_pat  = {cyc_pat[5:0], wb_cyc_o};
            stb_pat  = {stb_pat[5:0], wb_stb_o};
            busy_pat = {busy_pat[5:0], coreBusy};
        end
        chk("b2b cyc pattern", {25'd0, cyc_pat}, {25'd0, 7'b0100100});
        chk("b2b stb pattern", {25'd0, stb_pat}, {25'd0, 7'b0100100});
        chk("b2b busy pattern", {25'd0, busy_pat}, {25'd0, 7'b1101100});
        chk("b2b rdata", coreDataRead, 32'h00000002);

        // Reset asserted while waiting for ack.
        for (int c = 1; c <= 3; c++) begin
            @(negedge wb_clk_i);
            idle_inputs();
            coreEnable     = 1'b1;
            coreAddress    = 28'h0ABCDEF;
            coreByteSelect = 4'hF;
        end
        #1;
        chk("rst pre cyc/stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd2);
        coreEnable = 1'b0;
        wb_rst_i   = 1'b0;
        #1;
        chk("rst mid cyc/stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("rst mid rdata", coreDataRead, 32'hFFFFFFFF);
        chk("rst mid adr/err", {wb_adr_o, 3'd0, coreError}, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        #1;
        chk("rst post busy/cyc", {30'd0, coreBusy, wb_cyc_o}, 32'd0);
        run_vec(10, vt[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
